// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for DIV/DIVU, one quotient bit per clock
//
// Purpose:
//   Multi-cycle divider that sits beside EX and feeds HI/LO. The pipeline
//   issues an operation with a one-cycle start, stalls while busy_o is high,
//   and writes LO/HI when done_o pulses.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   start_i      in   capture operands and begin (accepted in IDLE or DONE)
//   signed_i     in   1 = signed DIV, 0 = unsigned DIVU (sampled with start_i)
//   dividend_i   in   dividend (sampled with start_i)
//   divisor_i    in   divisor (sampled with start_i)
//   flush_i      in   abort the current operation, outputs left untouched
//   busy_o       out  operation in progress
//   done_o       out  one-cycle pulse, quotient_o/remainder_o valid
//   quotient_o   out  quotient (LO)
//   remainder_o  out  remainder (HI)

module div_unit #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o
);

  localparam int CntW = $clog2(Width + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [Width-1:0] quo_q;       // dividend magnitude shifting out, quotient shifting in
  logic [Width-1:0] rem_q;       // partial remainder, always < divisor after each step
  logic [Width-1:0] dvs_q;       // divisor magnitude
  logic [Width-1:0] dvd_raw_q;   // original dividend, returned as remainder on divide by zero
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div_zero_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [Width-1:0] dvd_mag;
  logic [Width-1:0] dvs_mag;
  logic [Width:0]   rem_sh;
  logic [Width:0]   diff;
  logic             fits;
  logic [Width-1:0] quo_fix;
  logic [Width-1:0] rem_fix;

  assign dvd_neg = signed_i & dividend_i[Width-1];
  assign dvs_neg = signed_i & divisor_i[Width-1];
  // Negating the most-negative value wraps to itself, which is the correct
  // unsigned magnitude, so overflow needs no special case.
  assign dvd_mag = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign dvs_mag = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;

  // The shifted partial remainder needs Width+1 bits; the MSB of the
  // trial difference is the borrow that decides restore vs keep.
  assign rem_sh = {rem_q, quo_q[Width-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign fits   = ~diff[Width];

  assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else if (start_i) begin
            quo_q      <= dvd_mag;
            dvs_q      <= dvs_mag;
            rem_q      <= '0;
            dvd_raw_q  <= dividend_i;
            neg_quo_q  <= dvd_neg ^ dvs_neg;
            neg_rem_q  <= dvd_neg;
            div_zero_q <= (divisor_i == '0);
            cnt_q      <= CntW'(Width);
            busy_o     <= 1'b1;
            state_q    <= S_CALC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          if (flush_i) begin
            busy_o  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q != '0) begin
            rem_q <= fits ? diff[Width-1:0] : rem_sh[Width-1:0];
            quo_q <= {quo_q[Width-2:0], fits};
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            // Extra cycle after the last iteration registers the
            // sign-corrected results.
            quotient_o  <= div_zero_q ? '1 : quo_fix;
            remainder_o <= div_zero_q ? dvd_raw_q : rem_fix;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit

module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;

  int checks   = 0;
  int failures = 0;

  div_unit #(.Width(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .signed_i    (sgn),
    .dividend_i  (dvd),
    .divisor_i   (dvs),
    .flush_i     (flush),
    .busy_o      (busy),
    .done_o      (done),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Issues one operation, waits for done and checks
  // latency, busy shape and results. Returns at the negedge of the done cycle.
  // pulse_at > 0 re-pulses start with other operands during CALC.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input int pulse_at);
    int n;
    int busy_bad;
    n = 0;
    busy_bad = 0;
    sgn = s; dvd = a; dvs = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (busy !== 1'b1) busy_bad++;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      if (n == pulse_at) begin
        start = 1'b1; sgn = 1'b1; dvd = 32'd9; dvs = 32'd3;
      end
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_bad++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'd33);
    chk({tag, "_busy_gap"}, 32'(busy_bad), 32'd0);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_quo"}, quo, eq);
    chk({tag, "_rem"}, rem, er);
  endtask

  // Counts done pulses and busy cycles over a window, from a negedge.
  task automatic quiet_window(input string tag, input int cycles);
    int d;
    int b;
    d = 0;
    b = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) d++;
      if (busy === 1'b1) b++;
    end
    chk({tag, "_no_done"}, 32'(d), 32'd0);
    chk({tag, "_no_busy"}, 32'(b), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; dvd = '0; dvs = '0; flush = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quo", quo, 32'd0);
    chk("rst_rem", rem, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned 100 / 7, then done must be a single-cycle pulse
    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    @(negedge clk);
    chk("u100_7_done_pulse", {31'd0, done}, 32'd0);
    chk("u100_7_idle_busy", {31'd0, busy}, 32'd0);

    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
    @(negedge clk);
    run_op("u_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 0);
    @(negedge clk);
    run_op("u_dz", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
    @(negedge clk);
    run_op("s_dz", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
    @(negedge clk);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
    @(negedge clk);

    // start re-pulsed mid-CALC with 9/3 signed must be ignored
    run_op("restart_ign", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 5);
    @(negedge clk);

    // flush at iteration 10 (before edge k+10)
    sgn = 1'b0; dvd = 32'd50; dvs = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_drop", {31'd0, busy}, 32'd0);
    quiet_window("flush", 40);
    chk("flush_quo_kept", quo, 32'd100);
    chk("flush_rem_kept", rem, 32'd0);

    // flush together with start in IDLE stays IDLE
    sgn = 1'b0; dvd = 32'd77; dvs = 32'd7; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_start_busy", {31'd0, busy}, 32'd0);
    quiet_window("idle_flush_start", 40);
    chk("idle_flush_quo_kept", quo, 32'd100);

    // asynchronous reset mid-CALC
    sgn = 1'b0; dvd = 32'd100; dvs = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_quo", quo, 32'd0);
    chk("arst_rem", rem, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window("arst", 40);

    // back-to-back: start in the DONE cycle
    run_op("b2b_first", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    chk("b2b_done_seen", {31'd0, done}, 32'd1);
    run_op("b2b_second", 1'b0, 32'd200, 32'd3, 32'd66, 32'd2, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
